// File: rtl/fetcher_pkg.sv
// Types shared between the per-compute-unit fetcher and the instruction cache.
// The fetch request struct is fixed at the compute unit's default widths.
package fetcher_pkg;

    localparam int unsigned CuPcWidth   = 32;
    localparam int unsigned CuWarpWidth = 32;
    localparam int unsigned CuNumWarps  = 8;
    localparam int unsigned CuWidWidth  = CuNumWarps > 1 ? $clog2(CuNumWarps) : 1;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        READY   = 2'd1,
        WAITING = 2'd2
    } warp_state_e;

    typedef struct packed {
        logic [CuPcWidth-1:0]   pc;
        logic [CuWarpWidth-1:0] act_mask;
        logic [CuWidWidth-1:0]  warp_id;
    } fetch_req_t;

endpackage

// File: rtl/fetch_rr_select.sv
// Combinational round-robin pick of one READY warp, searching upward from
// rr_ptr_i and wrapping at NumWarps-1.
module fetch_rr_select #(
    parameter int unsigned NumWarps = 8,
    parameter int unsigned WidWidth = NumWarps > 1 ? $clog2(NumWarps) : 1
) (
    input  logic [NumWarps-1:0] ready_i,
    input  logic [WidWidth-1:0] rr_ptr_i,
    output logic                gnt_valid_o,
    output logic [WidWidth-1:0] gnt_idx_o
);

    logic [NumWarps-1:0] rotated;
    logic [WidWidth-1:0] offset;
    logic [WidWidth:0]   sum;

    // Rotate so bit 0 is the slot at rr_ptr_i; the lowest set bit is the winner.
    always_comb begin
        rotated     = NumWarps'({ready_i, ready_i} >> rr_ptr_i);
        gnt_valid_o = 1'b0;
        offset      = '0;
        for (int k = int'(NumWarps) - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                gnt_valid_o = 1'b1;
                offset      = WidWidth'(k);
            end
        end
        sum = {1'b0, rr_ptr_i} + {1'b0, offset};
        if (sum >= (WidWidth + 1)'(NumWarps)) begin
            sum = sum - (WidWidth + 1)'(NumWarps);
        end
        gnt_idx_o = sum[WidWidth-1:0];
    end

endmodule

// File: rtl/lzc.sv
// Leading/trailing zero counter, interface-compatible with the common_cells lzc.
// MODE 0 counts trailing zeros (index of the lowest set bit).
module lzc #(
    parameter int unsigned WIDTH     = 2,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = WIDTH > 1 ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    always_comb begin
        cnt_o   = '0;
        empty_o = ~|in_i;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                cnt_o = MODE ? CNT_WIDTH'(int'(WIDTH) - 1 - i) : CNT_WIDTH'(i);
                if (MODE) begin
                    break;
                end
            end
        end
    end

endmodule

// File: rtl/fetcher.sv
// Instruction fetcher: per-slot warp state, allocation of new warps, round-robin
// fetch selection with a stable (locked) request towards the instruction cache.
module fetcher
    import fetcher_pkg::*;
#(
    parameter int unsigned PcWidth   = 32,
    parameter int unsigned NumWarps  = 8,
    parameter int unsigned WarpWidth = 32,
    parameter int unsigned WidWidth  = NumWarps > 1 ? $clog2(NumWarps) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_valid_i,
    output logic                 start_ready_o,
    input  logic [PcWidth-1:0]   start_pc_i,
    input  logic [WarpWidth-1:0] start_act_mask_i,
    output logic [WidWidth-1:0]  start_warp_id_o,
    input  logic                 ic_ready_i,
    output logic                 fe_valid_o,
    output logic [PcWidth-1:0]   fe_pc_o,
    output logic [WarpWidth-1:0] fe_act_mask_o,
    output logic [WidWidth-1:0]  fe_warp_id_o,
    input  logic                 upd_valid_i,
    input  logic [WidWidth-1:0]  upd_warp_id_i,
    input  logic [PcWidth-1:0]   upd_pc_i,
    input  logic [WarpWidth-1:0] upd_act_mask_i,
    input  logic                 upd_stop_i,
    output logic                 busy_o
);

    warp_state_e          state_q [NumWarps];
    warp_state_e          state_d [NumWarps];
    logic [PcWidth-1:0]   pc_q    [NumWarps];
    logic [PcWidth-1:0]   pc_d    [NumWarps];
    logic [WarpWidth-1:0] mask_q  [NumWarps];
    logic [WarpWidth-1:0] mask_d  [NumWarps];
    logic [WidWidth-1:0]  rr_ptr_q, rr_ptr_d;
    logic                 lock_q, lock_d;
    logic [WidWidth-1:0]  lock_wid_q, lock_wid_d;

    logic [NumWarps-1:0]  readyMask, freeMask;
    logic [WidWidth-1:0]  freeIdx, selIdx, feWid;
    logic                 noFree, selValid, feValid;

    always_comb begin
        readyMask = '0;
        freeMask  = '0;
        for (int i = 0; i < int'(NumWarps); i++) begin
            readyMask[i] = (state_q[i] == READY);
            freeMask[i]  = (state_q[i] == FREE);
        end
    end

    lzc #(
        .WIDTH     (NumWarps),
        .MODE      (1'b0),
        .CNT_WIDTH (WidWidth)
    ) u_free_lzc (
        .in_i    (freeMask),
        .cnt_o   (freeIdx),
        .empty_o (noFree)
    );

    fetch_rr_select #(
        .NumWarps (NumWarps),
        .WidWidth (WidWidth)
    ) u_rr_select (
        .ready_i     (readyMask),
        .rr_ptr_i    (rr_ptr_q),
        .gnt_valid_o (selValid),
        .gnt_idx_o   (selIdx)
    );

    // A stalled request keeps presenting the same slot until the cache takes it.
    assign feValid         = lock_q | selValid;
    assign feWid           = lock_q ? lock_wid_q : selIdx;
    assign fe_valid_o      = feValid;
    assign fe_warp_id_o    = feValid ? feWid : '0;
    assign fe_pc_o         = feValid ? pc_q[feWid] : '0;
    assign fe_act_mask_o   = feValid ? mask_q[feWid] : '0;
    assign start_ready_o   = ~noFree;
    assign start_warp_id_o = freeIdx;
    assign busy_o          = ~&freeMask;

    // Start, fetch and update always hit slots in distinct states, so all apply.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mask_d     = mask_q;
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_wid_d = lock_wid_q;

        if (start_valid_i && !noFree) begin
            state_d[freeIdx] = READY;
            pc_d[freeIdx]    = start_pc_i;
            mask_d[freeIdx]  = start_act_mask_i;
        end

        if (feValid) begin
            if (ic_ready_i) begin
                state_d[feWid] = WAITING;
                rr_ptr_d       = (feWid == WidWidth'(NumWarps - 1)) ? '0 : feWid + WidWidth'(1);
                lock_d         = 1'b0;
            end else begin
                lock_d     = 1'b1;
                lock_wid_d = feWid;
            end
        end

        if (upd_valid_i && state_q[upd_warp_id_i] == WAITING) begin
            if (upd_stop_i) begin
                state_d[upd_warp_id_i] = FREE;
                pc_d[upd_warp_id_i]    = '0;
                mask_d[upd_warp_id_i]  = '0;
            end else begin
                state_d[upd_warp_id_i] = READY;
                pc_d[upd_warp_id_i]    = upd_pc_i;
                mask_d[upd_warp_id_i]  = upd_act_mask_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumWarps); i++) begin
                state_q[i] <= FREE;
                pc_q[i]    <= '0;
                mask_q[i]  <= '0;
            end
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_wid_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mask_q     <= mask_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_wid_q <= lock_wid_d;
        end
    end

    always @(posedge clk_i) begin
        if (rst_ni && upd_valid_i) begin
            assert (state_q[upd_warp_id_i] == WAITING)
                else $error("fetcher: update to non-WAITING warp slot %0d", upd_warp_id_i);
        end
    end

endmodule

// File: tb/tb_fetcher.sv
// Self-checking bench for fetcher: a slot-level reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_fetcher;

    localparam int N = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_valid_i = 1'b0;
    logic        start_ready_o;
    logic [31:0] start_pc_i = '0;
    logic [31:0] start_act_mask_i = '0;
    logic [2:0]  start_warp_id_o;
    logic        ic_ready_i = 1'b0;
    logic        fe_valid_o;
    logic [31:0] fe_pc_o;
    logic [31:0] fe_act_mask_o;
    logic [2:0]  fe_warp_id_o;
    logic        upd_valid_i = 1'b0;
    logic [2:0]  upd_warp_id_i = '0;
    logic [31:0] upd_pc_i = '0;
    logic [31:0] upd_act_mask_i = '0;
    logic        upd_stop_i = 1'b0;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    fetcher dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .start_valid_i    (start_valid_i),
        .start_ready_o    (start_ready_o),
        .start_pc_i       (start_pc_i),
        .start_act_mask_i (start_act_mask_i),
        .start_warp_id_o  (start_warp_id_o),
        .ic_ready_i       (ic_ready_i),
        .fe_valid_o       (fe_valid_o),
        .fe_pc_o          (fe_pc_o),
        .fe_act_mask_o    (fe_act_mask_o),
        .fe_warp_id_o     (fe_warp_id_o),
        .upd_valid_i      (upd_valid_i),
        .upd_warp_id_i    (upd_warp_id_i),
        .upd_pc_i         (upd_pc_i),
        .upd_act_mask_i   (upd_act_mask_i),
        .upd_stop_i       (upd_stop_i),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: slot table (0 free, 1 ready, 2 waiting), next search start, held request.
    int          mState [N];
    logic [31:0] mPc [N];
    logic [31:0] mMask [N];
    int          mSearchFrom;
    bit          mHeld;
    int          mHeldWid;
    bit          modelLive = 1'b0;

    function automatic void presented(output bit v, output int w);
        v = mHeld;
        w = mHeldWid;
        if (!mHeld) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (mState[(mSearchFrom + k) % N] == 1) begin
                    v = 1'b1;
                    w = (mSearchFrom + k) % N;
                end
            end
        end
    endfunction

    function automatic int lowestFree();
        for (int s = 0; s < N; s++) begin
            if (mState[s] == 0) return s;
        end
        return -1;
    endfunction

    always @(posedge clk_i) begin
        bit fv;
        int fw;
        int fs;
        if (!rst_ni) begin
            for (int s = 0; s < N; s++) begin
                mState[s] = 0;
                mPc[s]    = '0;
                mMask[s]  = '0;
            end
            mSearchFrom = 0;
            mHeld       = 1'b0;
            mHeldWid    = 0;
            modelLive   = 1'b1;
        end else if (modelLive) begin
            presented(fv, fw);
            fs = lowestFree();
            if (start_valid_i && fs >= 0) begin
                mState[fs] = 1;
                mPc[fs]    = start_pc_i;
                mMask[fs]  = start_act_mask_i;
            end
            if (fv && ic_ready_i) begin
                mState[fw]  = 2;
                mSearchFrom = (fw + 1) % N;
                mHeld       = 1'b0;
            end else if (fv) begin
                mHeld    = 1'b1;
                mHeldWid = fw;
            end
            if (upd_valid_i && mState[upd_warp_id_i] == 2) begin
                mState[upd_warp_id_i] = upd_stop_i ? 0 : 1;
                mPc[upd_warp_id_i]    = upd_stop_i ? 32'h0 : upd_pc_i;
                mMask[upd_warp_id_i]  = upd_stop_i ? 32'h0 : upd_act_mask_i;
            end
        end
    end

    // Outputs depend on registered state only, so every negedge is a valid sample point.
    always @(negedge clk_i) begin
        bit ev;
        int ew;
        int fs;
        int live;
        if (modelLive) begin
            presented(ev, ew);
            fs   = lowestFree();
            live = 0;
            for (int s = 0; s < N; s++) live += (mState[s] != 0) ? 1 : 0;
            checkOutput("model fe_valid", {31'b0, fe_valid_o}, {31'b0, ev});
            checkOutput("model fe_warp_id", {29'b0, fe_warp_id_o}, ev ? ew : 0);
            checkOutput("model fe_pc", fe_pc_o, ev ? mPc[ew] : 32'h0);
            checkOutput("model fe_act_mask", fe_act_mask_o, ev ? mMask[ew] : 32'h0);
            checkOutput("model start_ready", {31'b0, start_ready_o}, (fs >= 0) ? 1 : 0);
            if (fs >= 0) checkOutput("model start_warp_id", {29'b0, start_warp_id_o}, fs);
            checkOutput("model busy", {31'b0, busy_o}, (live != 0) ? 1 : 0);
        end
    end

    task automatic applyStimulus(input bit sv, input logic [31:0] spc, input bit icr,
                                 input bit uv, input int uwid, input logic [31:0] upc,
                                 input bit ustop);
        start_valid_i    = sv;
        start_pc_i       = spc;
        start_act_mask_i = sv ? ~spc : 32'h0;
        ic_ready_i       = icr;
        upd_valid_i      = uv;
        upd_warp_id_i    = 3'(uwid);
        upd_pc_i         = upc;
        upd_act_mask_i   = uv ? {upc[15:0], upc[15:0]} : 32'h0;
        upd_stop_i       = ustop;
        @(negedge clk_i);
    endtask

    task automatic doReset(input int cycles);
        rst_ni = 1'b0;
        for (int i = 0; i < cycles; i++) applyStimulus(1'b1, 32'hBAD0, 1'b1, 1'b0, 0, 32'h0, 1'b0);
        rst_ni = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 0, 32'h0, 1'b0);
    endtask

    initial begin
        int          order [7] = '{0, 1, 2, 0, 1, 2, 0};
        logic [31:0] curPc [3];
        int          uw;

        // Reset and single fetch of slot 0
        rst_ni = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 0, 32'h0, 1'b0);
        checkOutput("reset fe_valid", {31'b0, fe_valid_o}, 32'h0);
        checkOutput("reset start_ready", {31'b0, start_ready_o}, 32'h1);
        checkOutput("reset start_warp_id", {29'b0, start_warp_id_o}, 32'h0);
        checkOutput("reset busy", {31'b0, busy_o}, 32'h0);
        rst_ni = 1'b1;
        start_act_mask_i = 32'hFFFF_FFFF;
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 0, 32'h0, 1'b0);
        checkOutput("first fe_valid", {31'b0, fe_valid_o}, 32'h1);
        checkOutput("first fe_pc", fe_pc_o, 32'h100);
        checkOutput("first fe_warp_id", {29'b0, fe_warp_id_o}, 32'h0);
        checkOutput("first fe_mask", fe_act_mask_o, ~32'h100);
        checkOutput("first start_warp_id", {29'b0, start_warp_id_o}, 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 0, 32'h0, 1'b0);
        checkOutput("waiting fe_valid", {31'b0, fe_valid_o}, 32'h0);
        checkOutput("waiting busy", {31'b0, busy_o}, 32'h1);

        // Round-robin over three warps with updates one cycle after each fetch
        doReset(1);
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc >= 1) begin
                checkOutput("rr grant", {29'b0, fe_warp_id_o}, order[cyc-1]);
                checkOutput("rr pc", fe_pc_o, curPc[order[cyc-1]]);
            end
            if (cyc < 3) curPc[cyc] = 32'h200 + 32'h100 * cyc;
            uw = (cyc >= 2) ? order[cyc-2] : 0;
            if (cyc >= 2) curPc[uw] = curPc[uw] + 1;
            applyStimulus(cyc < 3, (cyc < 3) ? curPc[cyc] : 32'h0, 1'b1,
                          cyc >= 2, uw, curPc[uw], 1'b0);
        end

        // Locked request holds slot 2 while slot 1 becomes READY
        doReset(1);
        applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 0, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h20, 1'b1, 1'b0, 0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0,  1'b1, 1'b1, 0, 32'h11, 1'b0);
        applyStimulus(1'b1, 32'h30, 1'b1, 1'b0, 0, 32'h0, 1'b0);
        checkOutput("lock presented", {29'b0, fe_warp_id_o}, 32'h2);
        applyStimulus(1'b0, 32'h0,  1'b0, 1'b0, 0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0,  1'b0, 1'b1, 1, 32'h0, 1'b1);
        checkOutput("lock free slot", {29'b0, start_warp_id_o}, 32'h1);
        applyStimulus(1'b1, 32'h50, 1'b0, 1'b0, 0, 32'h0, 1'b0);
        checkOutput("lock held", {29'b0, fe_warp_id_o}, 32'h2);
        checkOutput("lock held pc", fe_pc_o, 32'h30);
        applyStimulus(1'b0, 32'h0,  1'b0, 1'b0, 0, 32'h0, 1'b0);
        checkOutput("lock still held", {29'b0, fe_warp_id_o}, 32'h2);
        applyStimulus(1'b0, 32'h0,  1'b1, 1'b0, 0, 32'h0, 1'b0);
        checkOutput("lock wrap grant", {29'b0, fe_warp_id_o}, 32'h1);
        checkOutput("lock wrap pc", fe_pc_o, 32'h50);

        // Fill every slot, then free slot 5 while a start is offered
        doReset(1);
        for (int k = 0; k < N; k++) begin
            checkOutput("fill start_warp_id", {29'b0, start_warp_id_o}, k);
            applyStimulus(1'b1, 32'h1000 + k, 1'b1, 1'b0, 0, 32'h0, 1'b0);
        end
        checkOutput("full start_ready", {31'b0, start_ready_o}, 32'h0);
        applyStimulus(1'b1, 32'hDEAD, 1'b0, 1'b1, 5, 32'h0, 1'b1);
        checkOutput("freed start_ready", {31'b0, start_ready_o}, 32'h1);
        checkOutput("freed start_warp_id", {29'b0, start_warp_id_o}, 32'h5);
        applyStimulus(1'b1, 32'h2000, 1'b1, 1'b0, 0, 32'h0, 1'b0);
        checkOutput("refill grant", {29'b0, fe_warp_id_o}, 32'h5);
        checkOutput("refill pc", fe_pc_o, 32'h2000);

        // Reset while four warps are live and a request is stalled
        doReset(1);
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 32'h40 * (k + 1), 1'b0, 1'b0, 0, 32'h0, 1'b0);
        checkOutput("pre-reset fe_valid", {31'b0, fe_valid_o}, 32'h1);
        rst_ni = 1'b0;
        applyStimulus(1'b1, 32'h77, 1'b0, 1'b0, 0, 32'h0, 1'b0);
        rst_ni = 1'b1;
        checkOutput("post-reset fe_valid", {31'b0, fe_valid_o}, 32'h0);
        checkOutput("post-reset busy", {31'b0, busy_o}, 32'h0);
        checkOutput("post-reset start_warp_id", {29'b0, start_warp_id_o}, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetcher.md
# fetcher

Per-compute-unit instruction fetcher, directly upstream of the instruction cache. Tracks the PC, active mask and fetch state of every warp slot, accepts new warps from the dispatcher, selects one fetch-ready warp per cycle round-robin, and presents its fetch request to the instruction cache. At most one instruction per warp is in flight. A warp becomes fetch-ready again only when the downstream issue logic reports that warp's next PC, or its termination.

## Interface
Parameters:
- PcWidth, 32, program counter width
- NumWarps, 8, warp slots per compute unit
- WarpWidth, 32, threads per warp
- WidWidth, NumWarps > 1 ? $clog2(NumWarps) : 1, derived; do not override

Ports:
- Clock and reset: one clock; reset is synchronous and active-low. Named `clk_i` and `rst_ni`.
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- start_valid_i  in  1  dispatcher offers a new warp
- start_ready_o  out  1  a FREE slot exists
- start_pc_i  in  PcWidth  first PC of the new warp
- start_act_mask_i  in  WarpWidth  initial active mask
- start_warp_id_o  out  WidWidth  slot that would be or is allocated (lowest FREE index)
- ic_ready_i  in  1  instruction cache accepts request
- fe_valid_o  out  1  fetch request valid
- fe_pc_o  out  PcWidth  PC to fetch
- fe_act_mask_o  out  WarpWidth  active mask of fetched warp
- fe_warp_id_o  out  WidWidth  warp slot of fetched warp
- upd_valid_i  in  1  next-PC update for a WAITING warp
- upd_warp_id_i  in  WidWidth  warp being updated
- upd_pc_i  in  PcWidth  next PC
- upd_act_mask_i  in  WarpWidth  new active mask
- upd_stop_i  in  1  warp finished; free its slot
- busy_o  out  1  any slot not FREE

## Operation
- Each slot holds a state, a PC and an active mask. Slot states are FREE, READY and WAITING.
- Start:
  - If start_valid_i && start_ready_o, the lowest-index FREE slot is allocated.
  - Its PC and mask are loaded and its state becomes READY.
  - start_ready_o = OR of FREE over all slots.
- Select:
  - Round-robin over READY slots, searching from rr_ptr upward with wrap at NumWarps-1 → 0.
  - fe_valid_o = any READY slot, or lock_q set.
- Lock (stable request):
  - If fe_valid_o && !ic_ready_i, set lock_q and store the chosen slot in lock_wid_q.
  - While lock_q is set, the presented slot does not change, even if other slots become READY.
- Fetch handshake (fe_valid_o && ic_ready_i):
  - The granted slot becomes WAITING.
  - rr_ptr = granted+1 mod NumWarps.
  - lock_q clears.
- Update (upd_valid_i):
  - Applies only to a WAITING slot. It loads the PC and mask, and the slot becomes READY.
  - If upd_stop_i is set, the slot becomes FREE instead and its PC/mask are cleared to 0.
  - An update to a non-WAITING slot is ignored and fires a simulation assertion.
- Simultaneous events:
  - Start, update and fetch can occur in the same cycle. They always target distinct slots, so all three apply.
  - A slot freed by an update is not allocatable until the next cycle, because start_ready_o is computed from registered state.
- fe_pc_o, fe_act_mask_o and fe_warp_id_o are driven to 0 when fe_valid_o is low.

## Timing
- All state registers update on the rising edge of clk_i.
- Reset is applied when rst_ni is low at a clock edge. It sets:
  - all slots FREE, PC 0, mask 0
  - rr_ptr 0
  - lock_q 0
- Outputs after reset: fe_valid_o 0, start_ready_o 1, start_warp_id_o 0, busy_o 0, fe_* data 0.
- Reset mid-operation discards all in-flight warps. Any outstanding fetch is dropped, and fe_valid_o is 0 in the first cycle after reset.
- All outputs are combinational from registered state only; there is no input→output combinational path.
- Latencies:
  - Start accepted in cycle t → fe_valid_o for that warp no earlier than t+1.
  - Update in cycle t → the warp is fetchable no earlier than t+1.
- Throughput: one fetch per cycle when the instruction cache is ready and READY slots exist.

## Structure
- The compute-unit shared package holds:
  - the `warp_state_e` enum (FREE/READY/WAITING, 2 bits)
  - the `fetch_req_t` struct {pc, act_mask, warp_id}, the same struct the instruction cache registers internally
- One natural sub-module, `fetch_rr_select`:
  - parametrised by NumWarps
  - input: ready mask and rr_ptr
  - outputs: grant valid and grant index; purely combinational
- First-free-slot search is a leading-zero count, using the common_cells lzc module.

## Test plan
- Reset, then start (pc=0x100, mask=0xFFFF_FFFF) with ic_ready_i=1 → slot 0 allocated; next cycle fe_valid_o=1, fe_pc_o=0x100, fe_warp_id_o=0; slot 0 WAITING afterwards, fe_valid_o=0.
- Start warps into slots 0,1,2 while ic_ready_i=1 constantly, updating each with pc+1 one cycle after its fetch → grant order 0,1,2,0,1,2.
- Hold ic_ready_i=0 with slot 2 presented, then start a warp into slot 1 → fe_warp_id_o stays 2 until ic_ready_i=1; next grant is slot 1 only after rr_ptr wraps past 3..7.
- Fill all NumWarps=8 slots → start_ready_o=0; update slot 5 with upd_stop_i=1 → the next cycle start_ready_o=1 and start_warp_id_o=5.
- Update on a READY or FREE slot → state unchanged, assertion fires.
- Assert rst_ni=0 for one cycle while 4 warps are active and fe_valid_o=1 → next cycle fe_valid_o=0, busy_o=0, start_warp_id_o=0.
